// File: rtl/dedisp_frame_accumulator_if.sv
// ---------------------------------------------------------------------------
// dedisp_frame_accumulator_if
//   Stream and result bundle between the serial dedispersor output and the
//   frame accumulator.
//   Stream (driven by master): din, din_valid, din_sof, din_eof, threshold
//   Result (driven by slave):  dout, dout_valid, detect, frame_err,
//                              good_frames, bad_frames
// ---------------------------------------------------------------------------
interface dedisp_frame_accumulator_if #(
    parameter int DIN_WIDTH  = 32,
    parameter int DOUT_WIDTH = 35,
    parameter int CNT_WIDTH  = 32
);
    logic [DIN_WIDTH-1:0]  din;
    logic                  din_valid;
    logic                  din_sof;
    logic                  din_eof;
    logic [DOUT_WIDTH-1:0] threshold;

    logic [DOUT_WIDTH-1:0] dout;
    logic                  dout_valid;
    logic                  detect;
    logic                  frame_err;
    logic [CNT_WIDTH-1:0]  good_frames;
    logic [CNT_WIDTH-1:0]  bad_frames;

    modport slave (
        input  din, din_valid, din_sof, din_eof, threshold,
        output dout, dout_valid, detect, frame_err, good_frames, bad_frames
    );

    modport master (
        output din, din_valid, din_sof, din_eof, threshold,
        input  dout, dout_valid, detect, frame_err, good_frames, bad_frames
    );
endinterface

// File: rtl/dedisp_frame_accumulator.sv
// ---------------------------------------------------------------------------
// dedisp_frame_accumulator
//   Sums each sof..eof frame of N_CHANNELS dedispersed samples into one
//   integrated power value, flags it as a candidate when it exceeds a runtime
//   threshold, and counts well-formed and malformed frames.
//   Ports:
//     clk, rst - system clock, asynchronous active-high reset
//     ce       - clock enable; all state and outputs freeze while low
//     s        - stream in / result out bundle (slave side)
// ---------------------------------------------------------------------------
module dedisp_frame_accumulator #(
    parameter int N_CHANNELS = 8,
    parameter int DIN_WIDTH  = 32,
    parameter int DOUT_WIDTH = DIN_WIDTH + $clog2(N_CHANNELS),
    parameter int CNT_WIDTH  = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ce,
    dedisp_frame_accumulator_if.slave     s
);

    localparam int SW = $clog2(N_CHANNELS);
    localparam logic [SW-1:0] LAST_CNT = SW'(N_CHANNELS - 1);
    localparam logic [SW-1:0] ONE_CNT  = SW'(1);

    typedef enum logic {
        IDLE,
        ACCUM
    } state_t;

    state_t                state_q, state_d;
    logic [DOUT_WIDTH-1:0] acc_q, acc_d;
    logic [SW-1:0]         cnt_q, cnt_d;
    logic [DOUT_WIDTH-1:0] dout_q, dout_d;
    logic                  dout_valid_q, dout_valid_d;
    logic                  detect_q, detect_d;
    logic                  frame_err_q, frame_err_d;
    logic [CNT_WIDTH-1:0]  good_frames_q, good_frames_d;
    logic [CNT_WIDTH-1:0]  bad_frames_q, bad_frames_d;

    logic                  beat;
    logic                  err;
    logic [DOUT_WIDTH-1:0] sum;

    assign beat = ce && s.din_valid;
    assign sum  = acc_q + DOUT_WIDTH'(s.din);

    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        cnt_d         = cnt_q;
        dout_d        = dout_q;
        dout_valid_d  = dout_valid_q;
        detect_d      = detect_q;
        frame_err_d   = frame_err_q;
        good_frames_d = good_frames_q;
        bad_frames_d  = bad_frames_q;
        err           = 1'b0;

        // Pulses only clear on enabled edges so they stay visible through ce=0.
        if (ce) begin
            dout_valid_d = 1'b0;
            frame_err_d  = 1'b0;
        end

        if (beat) begin
            unique case (state_q)
                IDLE: begin
                    if (s.din_sof && !s.din_eof) begin
                        acc_d   = DOUT_WIDTH'(s.din);
                        cnt_d   = ONE_CNT;
                        state_d = ACCUM;
                    end else begin
                        // stray sample or a one-sample frame
                        err = 1'b1;
                    end
                end
                ACCUM: begin
                    if (s.din_sof && s.din_eof) begin
                        // restart immediately terminated: a single error
                        err     = 1'b1;
                        state_d = IDLE;
                    end else if (s.din_sof) begin
                        err   = 1'b1;
                        acc_d = DOUT_WIDTH'(s.din);
                        cnt_d = ONE_CNT;
                    end else if (s.din_eof) begin
                        state_d = IDLE;
                        if (cnt_q == LAST_CNT) begin
                            dout_d        = sum;
                            dout_valid_d  = 1'b1;
                            detect_d      = (sum > s.threshold);
                            good_frames_d = good_frames_q + 1'b1;
                        end else begin
                            err = 1'b1;
                        end
                    end else if (cnt_q == LAST_CNT) begin
                        // overlong frame; this sample is dropped
                        err     = 1'b1;
                        state_d = IDLE;
                    end else begin
                        acc_d = sum;
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (err) begin
            frame_err_d  = 1'b1;
            bad_frames_d = bad_frames_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            acc_q         <= '0;
            cnt_q         <= '0;
            dout_q        <= '0;
            dout_valid_q  <= 1'b0;
            detect_q      <= 1'b0;
            frame_err_q   <= 1'b0;
            good_frames_q <= '0;
            bad_frames_q  <= '0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            dout_q        <= dout_d;
            dout_valid_q  <= dout_valid_d;
            detect_q      <= detect_d;
            frame_err_q   <= frame_err_d;
            good_frames_q <= good_frames_d;
            bad_frames_q  <= bad_frames_d;
        end
    end

    assign s.dout        = dout_q;
    assign s.dout_valid  = dout_valid_q;
    assign s.detect      = detect_q;
    assign s.frame_err   = frame_err_q;
    assign s.good_frames = good_frames_q;
    assign s.bad_frames  = bad_frames_q;

endmodule

// File: tb/tb_dedisp_frame_accumulator.sv
// ---------------------------------------------------------------------------
// tb_dedisp_frame_accumulator
//   Directed bench for dedisp_frame_accumulator with a result scoreboard:
//   expected sums/detect flags are queued as frames are driven and popped
//   when dout_valid is observed.
// ---------------------------------------------------------------------------
module tb_dedisp_frame_accumulator;

    localparam int N  = 8;
    localparam int DW = 32;
    localparam int OW = DW + $clog2(N);
    localparam int CW = 32;

    logic clk = 1'b0;
    logic rst;
    logic ce;

    dedisp_frame_accumulator_if #(
        .DIN_WIDTH (DW),
        .DOUT_WIDTH(OW),
        .CNT_WIDTH (CW)
    ) bus ();

    dedisp_frame_accumulator #(
        .N_CHANNELS(N),
        .DIN_WIDTH (DW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ce (ce),
        .s  (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [OW-1:0] sum;
        logic          det;
    } exp_t;

    exp_t          sb[$];
    int            tests    = 0;
    int            fails    = 0;
    int            err_seen = 0;
    int            exp_err  = 0;
    logic [CW-1:0] exp_good = '0;
    logic [CW-1:0] exp_bad  = '0;
    logic          edge_ce  = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ce as seen by the edge that produced the outputs observed at negedge
    always @(posedge clk) edge_ce = ce;

    always @(negedge clk) begin
        exp_t e;
        if (!rst && edge_ce) begin
            if (bus.frame_err) err_seen++;
            if (bus.dout_valid) begin
                check("sb_nonempty", 64'(sb.size() > 0), 64'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("sb_dout", 64'(bus.dout), 64'(e.sum));
                    check("sb_detect", 64'(bus.detect), 64'(e.det));
                end
            end
        end
    end

    task automatic beat(input logic [DW-1:0] d, input logic sof, input logic eof);
        bus.din       = d;
        bus.din_valid = 1'b1;
        bus.din_sof   = sof;
        bus.din_eof   = eof;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.din_valid = 1'b0;
        bus.din_sof   = 1'b0;
        bus.din_eof   = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame(input logic [DW-1:0] v[N], input logic [OW-1:0] thr);
        logic [OW-1:0] s;
        s = '0;
        for (int i = 0; i < N; i++) s += OW'(v[i]);
        bus.threshold = thr;
        sb.push_back('{sum: s, det: (s > thr)});
        exp_good++;
        for (int i = 0; i < N; i++) beat(v[i], i == 0, i == N - 1);
    endtask

    task automatic bad_beat(input logic [DW-1:0] d, input logic sof, input logic eof);
        exp_err++;
        exp_bad++;
        beat(d, sof, eof);
    endtask

    logic [DW-1:0] ramp[N];
    logic [DW-1:0] fives[N];
    logic [CW-1:0] good_hold;

    initial begin
        for (int i = 0; i < N; i++) begin
            ramp[i]  = DW'(i + 1);
            fives[i] = DW'(5);
        end
        rst           = 1'b1;
        ce            = 1'b1;
        bus.din       = '0;
        bus.din_valid = 1'b0;
        bus.din_sof   = 1'b0;
        bus.din_eof   = 1'b0;
        bus.threshold = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_dout", 64'(bus.dout), 64'd0);
        check("rst_dout_valid", 64'(bus.dout_valid), 64'd0);
        check("rst_detect", 64'(bus.detect), 64'd0);
        check("rst_frame_err", 64'(bus.frame_err), 64'd0);
        check("rst_good", 64'(bus.good_frames), 64'd0);
        check("rst_bad", 64'(bus.bad_frames), 64'd0);
        rst = 1'b0;
        idle(1);

        // 1: ramp frame above threshold, result one clock after eof
        frame(ramp, OW'(30));
        check("t1_valid", 64'(bus.dout_valid), 64'd1);
        check("t1_dout", 64'(bus.dout), 64'd36);
        check("t1_detect", 64'(bus.detect), 64'd1);
        check("t1_good", 64'(bus.good_frames), 64'(exp_good));
        idle(1);
        check("t1_valid_pulse", 64'(bus.dout_valid), 64'd0);
        check("t1_dout_hold", 64'(bus.dout), 64'd36);
        check("t1_no_err", 64'(err_seen), 64'd0);

        // 2: sum equal to threshold (not greater), then back-to-back frame
        frame(ramp, OW'(36));
        check("t2a_valid", 64'(bus.dout_valid), 64'd1);
        check("t2a_detect", 64'(bus.detect), 64'd0);
        frame(fives, OW'(36));
        check("t2b_dout", 64'(bus.dout), 64'd40);
        check("t2b_detect", 64'(bus.detect), 64'd1);
        check("t2_good", 64'(bus.good_frames), 64'(exp_good));
        idle(2);

        // 3: short frame, frame running past N without eof, stray samples
        for (int i = 0; i < 4; i++) beat(DW'(i + 1), i == 0, 1'b0);
        bad_beat(DW'(5), 1'b0, 1'b1);
        for (int i = 0; i < N - 1; i++) beat(DW'(9), i == 0, 1'b0);
        bad_beat(DW'(9), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) bad_beat(DW'(3), 1'b0, 1'b0);
        idle(1);
        check("t3_bad", 64'(bus.bad_frames), 64'(exp_bad));
        check("t3_err_pulses", 64'(err_seen), 64'(exp_err));
        check("t3_good_unchanged", 64'(bus.good_frames), 64'(exp_good));
        // one-sample frame in IDLE, sof+eof restart in ACCUM
        bad_beat(DW'(7), 1'b1, 1'b1);
        beat(DW'(1), 1'b1, 1'b0);
        bad_beat(DW'(2), 1'b1, 1'b1);
        idle(1);
        check("t3_sofeof_bad", 64'(bus.bad_frames), 64'(exp_bad));
        frame(ramp, OW'(100));
        check("t3_clean_dout", 64'(bus.dout), 64'd36);
        check("t3_clean_detect", 64'(bus.detect), 64'd0);
        idle(1);

        // 4: restart on sample 4, then a full frame of max-value samples
        beat(DW'(1), 1'b1, 1'b0);
        beat(DW'(2), 1'b0, 1'b0);
        beat(DW'(3), 1'b0, 1'b0);
        bus.threshold = OW'(64'h7_FFFF_FFF8);
        sb.push_back('{sum: OW'(64'h7_FFFF_FFF8), det: 1'b0});
        exp_good++;
        bad_beat(DW'(32'hFFFF_FFFF), 1'b1, 1'b0);
        for (int i = 1; i < N; i++) beat(DW'(32'hFFFF_FFFF), 1'b0, i == N - 1);
        check("t4_dout", 64'(bus.dout), 64'h7_FFFF_FFF8);
        check("t4_detect_equal", 64'(bus.detect), 64'd0);
        idle(1);
        check("t4_bad", 64'(bus.bad_frames), 64'(exp_bad));
        check("t4_good", 64'(bus.good_frames), 64'(exp_good));

        // 5: gaps from din_valid low and ce low inside a frame
        bus.threshold = OW'(35);
        sb.push_back('{sum: OW'(36), det: 1'b1});
        exp_good++;
        for (int i = 0; i < N; i++) begin
            repeat ($urandom_range(0, 2)) begin
                if ($urandom_range(0, 1) == 0) begin
                    ce = 1'b1;
                    idle(1);
                end else begin
                    // ignored junk: valid with sof/eof while disabled
                    ce = 1'b0;
                    beat(DW'(32'hDEAD), 1'b1, 1'b1);
                end
            end
            ce = 1'b1;
            beat(ramp[i], i == 0, i == N - 1);
        end
        check("t5_valid", 64'(bus.dout_valid), 64'd1);
        check("t5_dout", 64'(bus.dout), 64'd36);
        good_hold = bus.good_frames;
        ce = 1'b0;
        beat(DW'(32'hBEEF), 1'b1, 1'b0);
        beat(DW'(32'hBEEF), 1'b0, 1'b1);
        check("t5_valid_hold", 64'(bus.dout_valid), 64'd1);
        check("t5_dout_hold", 64'(bus.dout), 64'd36);
        check("t5_good_hold", 64'(bus.good_frames), 64'(good_hold));
        check("t5_no_err", 64'(bus.frame_err), 64'd0);
        ce = 1'b1;
        idle(1);
        check("t5_valid_clear", 64'(bus.dout_valid), 64'd0);
        check("t5_good", 64'(bus.good_frames), 64'(exp_good));
        check("t5_bad", 64'(bus.bad_frames), 64'(exp_bad));

        // 6: asynchronous reset in the middle of sample 6
        for (int i = 0; i < 5; i++) beat(ramp[i], i == 0, 1'b0);
        bus.din       = DW'(6);
        bus.din_valid = 1'b1;
        #3;
        rst = 1'b1;
        #1;
        check("t6_dout", 64'(bus.dout), 64'd0);
        check("t6_detect", 64'(bus.detect), 64'd0);
        check("t6_valid", 64'(bus.dout_valid), 64'd0);
        check("t6_good", 64'(bus.good_frames), 64'd0);
        check("t6_bad", 64'(bus.bad_frames), 64'd0);
        exp_good = '0;
        exp_bad  = '0;
        #2;
        rst = 1'b0;
        idle(1);
        frame(ramp, OW'(35));
        check("t6_fresh_dout", 64'(bus.dout), 64'd36);
        check("t6_fresh_detect", 64'(bus.detect), 64'd1);
        idle(3);
        check("t6_good_after", 64'(bus.good_frames), 64'(exp_good));
        check("t6_bad_after", 64'(bus.bad_frames), 64'(exp_bad));

        check("end_sb_drained", 64'(sb.size()), 64'd0);
        check("end_err_pulses", 64'(err_seen), 64'(exp_err));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
